serial_subtractor: RTL

Bit-serial WIDTH-bit subtractor computing a − b − bin, LSB first, one bit per clock. It wraps a single full-subtractor cell with a registered borrow loop, operand shift registers, a bit counter and a start/done handshake. It sits directly upstream of the combinational full subtractor: each cycle it feeds the cell one bit pair plus the stored borrow, and it collects the cell's Difference and Borrow.

---
 rtl/serial_subtractor.sv | 131 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor computing a - b - bin, LSB first, one bit
//   per clock through a single full-subtractor cell with a registered borrow.
//   An operation takes WIDTH SHIFT cycles plus one DONE cycle.
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  request, sampled only in IDLE
//   a, b   minuend / subtrahend, sampled on the accepting edge
//   bin    initial borrow-in, sampled on the accepting edge
//   busy   high whenever not IDLE
//   done   one-cycle completion pulse
//   diff   result, held between operations
//   bout   final borrow out of the MSB, held between operations
//   ovf    signed overflow flag; only computed when SERIAL_SUB_SIGNED_EN is
//          defined, otherwise tied to 0
//
// Optional feature macro: SERIAL_SUB_SIGNED_EN
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; operands and borrow loaded on accept
// SHIFT | one bit pair through the full-subtractor cell per cycle
// DONE  | done pulse, results valid; returns to IDLE next cycle

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic             x, y, d, bo;
  logic [WIDTH-1:0] res_nxt;

  // Full-subtractor cell and the result word as it looks after this bit.
  assign x       = a_sr[0];
  assign y       = b_sr[0];
  assign d       = x ^ y ^ borrow;
  assign bo      = (~x & y) | (~(x ^ y) & borrow);
  assign res_nxt = {d, res_sr};

`ifndef SERIAL_SUB_SIGNED_EN
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bin;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_nxt[WIDTH-1:1];
          borrow <= bo;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            diff  <= res_nxt;
            bout  <= bo;
`ifdef SERIAL_SUB_SIGNED_EN
            // Overflow when the borrow into the MSB differs from the borrow out.
            ovf   <= borrow ^ bo;
`endif
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
